// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared opcodes, reply codes, command FSM states and helpers for soc_top
package soc_pkg;

    localparam logic [7:0] OP_GPIO_SET = 8'h47;
    localparam logic [7:0] OP_GPIO_OUT = 8'h4F;
    localparam logic [7:0] OP_GPIO_IN  = 8'h49;
    localparam logic [7:0] OP_PDM      = 8'h50;

    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARG1,
        ST_ARG2,
        ST_RESP,
        ST_WAIT_TX
    } cmd_state_e;

    function automatic logic [7:0] sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/soc_uart.sv
// rtl/soc_uart.sv - 8N1 UART receiver/transmitter pair, CLKS_PER_BIT clocks per bit
module soc_uart #(
    parameter int CLKS_PER_BIT = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_valid_q, rx_valid_d;

    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [8:0]    tx_frame_q, tx_frame_d;
    logic          uart_tx_q, uart_tx_d;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_END) begin
                // A start bit that has gone high again by mid-bit was a glitch.
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_END) begin
                rx_valid_d = rx_sync_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_frame_d = tx_frame_q;
        uart_tx_d  = uart_tx_q;
        if (!tx_busy_q) begin
            tx_cnt_d = '0;
            if (tx_tvalid) begin
                tx_busy_d  = 1'b1;
                tx_frame_d = {1'b1, tx_tdata};
                tx_bit_d   = '0;
                uart_tx_d  = 1'b0;
            end
        end else if (tx_cnt_q == BIT_END) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_d = 1'b0;
                uart_tx_d = 1'b1;
            end else begin
                uart_tx_d  = tx_frame_q[0];
                tx_frame_d = {1'b1, tx_frame_q[8:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
            uart_tx_q  <= 1'b1;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_frame_q <= tx_frame_d;
            uart_tx_q  <= uart_tx_d;
        end
    end

    assign rx_tdata  = rx_shift_q;
    assign rx_tvalid = rx_valid_q;
    assign tx_tready = !tx_busy_q;
    assign uart_tx   = uart_tx_q;

endmodule

// File: rtl/soc_top.sv
// rtl/soc_top.sv - UART-controlled GPIO/PDM SoC shell; define SOC_PDM_EN to include the PDM meter
module soc_top #(
    parameter int CLKS_PER_BIT    = 50,
    parameter int PDM_WINDOW_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_pdm,
    input  logic        pdm_input,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic        uart_tx,
    input  logic        uart_rx
);
    import soc_pkg::*;

    logic [7:0]  rx_tdata;
    logic        rx_tvalid, tx_tready, tx_tvalid;
    logic [7:0]  pdm_level;

    cmd_state_e  state_q, state_d;
    logic [7:0]  op_q, op_d, resp_q, resp_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] gpio_q, gpio_d, gpio_meta_q, gpio_sync_q;

    soc_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .tx_tdata  (resp_q),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        resp_d  = resp_q;
        gpio_d  = gpio_q;
        case (state_q)
            ST_IDLE: if (rx_tvalid) begin
                op_d = rx_tdata;
                case (rx_tdata)
                    OP_GPIO_SET, OP_GPIO_OUT, OP_GPIO_IN: state_d = ST_ARG1;
                    OP_PDM: begin
                        resp_d  = pdm_level;
                        state_d = ST_RESP;
                    end
                    default: begin
                        resp_d  = RSP_ERR;
                        state_d = ST_RESP;
                    end
                endcase
            end
            ST_ARG1: if (rx_tvalid) begin
                idx_d = rx_tdata[1:0];
                case (op_q)
                    OP_GPIO_SET: state_d = ST_ARG2;
                    OP_GPIO_OUT: begin
                        resp_d  = gpio_q[{rx_tdata[1:0], 3'b000} +: 8];
                        state_d = ST_RESP;
                    end
                    default: begin
                        resp_d  = gpio_sync_q[{rx_tdata[1:0], 3'b000} +: 8];
                        state_d = ST_RESP;
                    end
                endcase
            end
            ST_ARG2: if (rx_tvalid) begin
                gpio_d[{idx_q, 3'b000} +: 8] = rx_tdata;
                resp_d  = RSP_ACK;
                state_d = ST_RESP;
            end
            ST_RESP:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: if (tx_tready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            idx_q       <= '0;
            resp_q      <= '0;
            gpio_q      <= '0;
            gpio_meta_q <= '0;
            gpio_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            resp_q      <= resp_d;
            gpio_q      <= gpio_d;
            gpio_meta_q <= gpio_i;
            gpio_sync_q <= gpio_meta_q;
        end
    end

    assign tx_tvalid = (state_q == ST_WAIT_TX);
    assign gpio_o    = gpio_q;

`ifdef SOC_PDM_EN
    localparam int PCW = PDM_WINDOW_LOG2 + 1;

    logic                       pdm_clk_meta_q, pdm_clk_sync_q, pdm_clk_prev_q;
    logic                       pdm_dat_meta_q, pdm_dat_sync_q;
    logic [PDM_WINDOW_LOG2-1:0] pdm_samp_q, pdm_samp_d;
    logic [PCW-1:0]             pdm_cnt_q, pdm_cnt_d, pdm_sum;
    logic [7:0]                 pdm_level_q, pdm_level_d;

    // The window's last sample is folded into the published level.
    always_comb begin
        pdm_samp_d  = pdm_samp_q;
        pdm_cnt_d   = pdm_cnt_q;
        pdm_level_d = pdm_level_q;
        pdm_sum     = pdm_cnt_q + PCW'(pdm_dat_sync_q);
        if (pdm_clk_sync_q && !pdm_clk_prev_q) begin
            pdm_samp_d = pdm_samp_q + 1'b1;
            if (&pdm_samp_q) begin
                pdm_cnt_d   = '0;
                pdm_level_d = sat_u8(32'(pdm_sum));
            end else begin
                pdm_cnt_d = pdm_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pdm_clk_meta_q <= 1'b0;
            pdm_clk_sync_q <= 1'b0;
            pdm_clk_prev_q <= 1'b0;
            pdm_dat_meta_q <= 1'b0;
            pdm_dat_sync_q <= 1'b0;
            pdm_samp_q     <= '0;
            pdm_cnt_q      <= '0;
            pdm_level_q    <= '0;
        end else begin
            pdm_clk_meta_q <= clk_pdm;
            pdm_clk_sync_q <= pdm_clk_meta_q;
            pdm_clk_prev_q <= pdm_clk_sync_q;
            pdm_dat_meta_q <= pdm_input;
            pdm_dat_sync_q <= pdm_dat_meta_q;
            pdm_samp_q     <= pdm_samp_d;
            pdm_cnt_q      <= pdm_cnt_d;
            pdm_level_q    <= pdm_level_d;
        end
    end

    assign pdm_level = pdm_level_q;
`else
    logic unused_pdm;
    assign unused_pdm = clk_pdm ^ pdm_input;
    assign pdm_level  = 8'h00;
`endif

endmodule

// File: tb/tb_soc_top.sv
// tb/tb_soc_top.sv - directed self-checking bench for soc_top
`timescale 1ns/1ps
module tb_soc_top;
    localparam int CPB = 50;
`ifdef SOC_PDM_EN
    localparam logic [7:0] EXP_P_ALT = 8'h80;
    localparam logic [7:0] EXP_P_SAT = 8'hFF;
`else
    localparam logic [7:0] EXP_P_ALT = 8'h00;
    localparam logic [7:0] EXP_P_SAT = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_pdm = 1'b0;
    logic        pdm_input = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] gpio_i = 32'h0;
    logic [31:0] gpio_o;
    logic        uart_tx;

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic [7:0]  mon_b;
    logic [7:0]  rx_q[$];
    int          pdm_mode = 0;

    soc_top #(.CLKS_PER_BIT(CPB), .PDM_WINDOW_LOG2(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_pdm   (clk_pdm),
        .pdm_input (pdm_input),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic expect_reply(input string tag, input logic [7:0] exp);
        int t;
        t = 0;
        while (rx_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " present"}, 32'(rx_q.size() != 0), 32'd1);
        if (rx_q.size() != 0) check({tag, " byte"}, 32'(rx_q.pop_front()), 32'(exp));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back(mon_b);
            end
        end
    end

    always @(negedge clk) begin
        if (pdm_mode != 0) begin
            clk_pdm = ~clk_pdm;
            if (clk_pdm) pdm_input = (pdm_mode == 2) ? 1'b1 : ~pdm_input;
        end
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        check("reset gpio_o", gpio_o, 32'h0);
        check("reset uart_tx", 32'(uart_tx), 32'd1);
        repeat (50000) @(negedge clk);
        check("idle no tx", 32'(rx_q.size()), 32'd0);

        send_byte(8'h47, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'hA5, 1'b1);
        check("G gpio_o", gpio_o, 32'h00A50000);
        expect_reply("G ack", 8'h4B);

        send_byte(8'h4F, 1'b1); send_byte(8'h02, 1'b1);
        expect_reply("O byte2", 8'hA5);

        gpio_i = 32'h12345678;
        repeat (5) @(negedge clk);
        send_byte(8'h49, 1'b1); send_byte(8'h00, 1'b1);
        expect_reply("I byte0", 8'h78);

        pdm_mode = 1;
        repeat (2000) @(negedge clk);
        send_byte(8'h50, 1'b1);
        expect_reply("P alternating", EXP_P_ALT);

        pdm_mode = 2;
        repeat (2000) @(negedge clk);
        send_byte(8'h50, 1'b1);
        expect_reply("P saturated", EXP_P_SAT);
        pdm_mode = 0;

        send_byte(8'h13, 1'b1);
        expect_reply("unknown op", 8'h3F);

        send_byte(8'h55, 1'b0);
        repeat (30 * CPB) @(negedge clk);
        check("framing no reply", 32'(rx_q.size()), 32'd0);
        send_byte(8'h4F, 1'b1); send_byte(8'h00, 1'b1);
        expect_reply("O after framing", 8'h00);

        send_byte(8'h47, 1'b1); send_byte(8'h01, 1'b1);
        repeat (5 * CPB) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset mid G gpio_o", gpio_o, 32'h0);
        check("reset mid G uart_tx", 32'(uart_tx), 32'd1);

        send_byte(8'h47, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h3C, 1'b1);
        check("G after reset gpio_o", gpio_o, 32'h00003C00);
        expect_reply("G after reset ack", 8'h4B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
